// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the camera pixel async FIFO (RClk domain) into a
// local burst buffer, then issues an SDRAM write burst with a frame-wrapping
// word address and streams the buffered beats on the controller's data pull.
module fifo_burst_reader #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned BURST_LEN   = 8,
   parameter int unsigned ADDR_WIDTH  = 22,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned FRAME_WORDS = 307200
) (
   input  logic                  RClk,
   input  logic                  PresetFull,
   input  logic                  Empty_in,
   input  logic [DATA_WIDTH-1:0] Data_in,
   output logic                  ReadEn_out,
   input  logic                  Frame_start,
   output logic                  Wr_req,
   input  logic                  Wr_ack,
   output logic [ADDR_WIDTH-1:0] Wr_addr,
   input  logic                  Wr_data_req,
   output logic [DATA_WIDTH-1:0] Wr_data,
   output logic                  Wr_done,
   output logic                  Frame_done
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
   localparam int unsigned IDX_W = $clog2(BURST_LEN);
   localparam int unsigned EXT_W = ADDR_WIDTH + 1;

   localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [EXT_W-1:0]      BURST_INC = EXT_W'(BURST_LEN);
   // One past the last word of a frame, kept one bit wider than the address
   localparam logic [EXT_W-1:0]      FRAME_END = EXT_W'(BASE_ADDR + FRAME_WORDS);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [CNT_W-1:0]      issued_cnt;
   logic [CNT_W-1:0]      captured_cnt;
   logic [IDX_W-1:0]      beat_idx;
   logic                  pop_d;
   logic [DATA_WIDTH-1:0] burst_buf [BURST_LEN];
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  restart_pending;

   logic                  pop;
   logic                  last_beat;
   logic                  apply_restart;
   logic [EXT_W-1:0]      addr_sum;
   logic                  wrap;

   // Next-state and control strobes for the FILL / REQ / XFER sequence
   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      last_beat     = 1'b0;
      apply_restart = 1'b0;
      addr_sum      = {1'b0, addr_q} + BURST_INC;
      wrap          = (addr_sum == FRAME_END);
      case (state_q)
         ST_FILL: begin
            pop           = !Empty_in && (issued_cnt < CNT_FULL);
            apply_restart = restart_pending && (issued_cnt == '0);
            if (pop_d && (captured_cnt == CNT_LAST)) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (Wr_ack) begin
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (Wr_data_req && (beat_idx == IDX_LAST)) begin
               last_beat     = 1'b1;
               apply_restart = restart_pending;
               state_d       = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // FIFO pop is combinational so a word can be requested every cycle
   assign ReadEn_out = pop && !PresetFull;

   // State register
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         state_q <= ST_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Pop/capture/beat counters; all cleared once the last beat leaves
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         issued_cnt   <= '0;
         captured_cnt <= '0;
         beat_idx     <= '0;
         pop_d        <= 1'b0;
      end else begin
         pop_d <= ReadEn_out;
         if (last_beat) begin
            issued_cnt   <= '0;
            captured_cnt <= '0;
            beat_idx     <= '0;
         end else begin
            if (ReadEn_out) begin
               issued_cnt <= issued_cnt + CNT_W'(1);
            end
            if (pop_d) begin
               captured_cnt <= captured_cnt + CNT_W'(1);
            end
            if ((state_q == ST_XFER) && Wr_data_req) begin
               beat_idx <= beat_idx + IDX_W'(1);
            end
         end
      end
   end

   // Burst buffer: FIFO data lands one cycle after its pop was accepted
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         for (int i = 0; i < int'(BURST_LEN); i++) begin
            burst_buf[i] <= '0;
         end
      end else if (pop_d) begin
         burst_buf[captured_cnt[IDX_W-1:0]] <= Data_in;
      end
   end

   // Registered beat output, kept equal to burst_buf[beat_idx]; the index
   // wraps to 0 on the last beat because BURST_LEN is a power of two
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         Wr_data <= '0;
      end else if (pop_d && (captured_cnt == '0)) begin
         Wr_data <= Data_in;
      end else if ((state_q == ST_XFER) && Wr_data_req) begin
         Wr_data <= burst_buf[beat_idx + IDX_W'(1)];
      end
   end

   // Burst address with frame wrap; a pending restart overrides both
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         addr_q <= BASE;
      end else if (apply_restart) begin
         addr_q <= BASE;
      end else if (last_beat) begin
         addr_q <= wrap ? BASE : addr_sum[ADDR_WIDTH-1:0];
      end
   end

   // Frame restart request, held until it can be applied between bursts
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         restart_pending <= 1'b0;
      end else if (apply_restart) begin
         restart_pending <= 1'b0;
      end else if (Frame_start) begin
         restart_pending <= 1'b1;
      end
   end

   // Controller-facing request and completion pulses
   always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
         Wr_req     <= 1'b0;
         Wr_done    <= 1'b0;
         Frame_done <= 1'b0;
      end else begin
         Wr_req     <= (state_d == ST_REQ);
         Wr_done    <= last_beat;
         Frame_done <= last_beat && wrap && !restart_pending;
      end
   end

   assign Wr_addr = addr_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model + SDRAM controller model drive the
// DUT; a scoreboard of expected beats and burst records is checked by a
// separate monitor.
module tb_fifo_burst_reader;

   localparam int unsigned DW     = 16;
   localparam int unsigned BL     = 8;
   localparam int unsigned AW     = 22;
   localparam int unsigned BASE   = 32'h100;
   localparam int unsigned FW     = 32;
   localparam int unsigned NBURST = FW / BL;

   logic          RClk = 1'b0;
   logic          PresetFull;
   logic          Empty_in;
   logic [DW-1:0] Data_in;
   logic          ReadEn_out;
   logic          Frame_start;
   logic          Wr_req;
   logic          Wr_ack;
   logic [AW-1:0] Wr_addr;
   logic          Wr_data_req;
   logic [DW-1:0] Wr_data;
   logic          Wr_done;
   logic          Frame_done;

   typedef struct {
      logic [AW-1:0] addr;
      bit            fd;
   } burst_t;

   logic [DW-1:0] fifo_q    [$];
   logic [DW-1:0] exp_data  [$];
   burst_t        exp_burst [$];

   int tests = 0;
   int fails = 0;
   int seg_idx = 0;
   int words_pushed = 0;
   int pops_total = 0;
   int stall_at = -1;
   int stall_len = 0;
   int stall_cnt = 0;
   bit rand_stall = 0;
   int ack_delay = 3;
   bit force_dreq = 1;
   int bursts_done = 0;
   int mon_beats = 0;
   bit mon_in_b = 0;

   fifo_burst_reader #(
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL),
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE),
      .FRAME_WORDS(FW)
   ) dut (
      .RClk       (RClk),
      .PresetFull (PresetFull),
      .Empty_in   (Empty_in),
      .Data_in    (Data_in),
      .ReadEn_out (ReadEn_out),
      .Frame_start(Frame_start),
      .Wr_req     (Wr_req),
      .Wr_ack     (Wr_ack),
      .Wr_addr    (Wr_addr),
      .Wr_data_req(Wr_data_req),
      .Wr_data    (Wr_data),
      .Wr_done    (Wr_done),
      .Frame_done (Frame_done)
   );

   always #5 RClk = ~RClk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: beats leave in FIFO order; burst k of a frame segment
   // goes to BASE + k*BL and the last burst of a frame raises Frame_done.
   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_data.push_back(w);
      words_pushed++;
      if (words_pushed % BL == 0) begin
         burst_t b;
         b.addr = AW'(BASE + BL * (seg_idx % NBURST));
         b.fd   = ((seg_idx % NBURST) == NBURST - 1);
         exp_burst.push_back(b);
         seg_idx++;
      end
   endtask

   task automatic wait_req(output int lat);
      lat = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge RClk); #3;
         if (Wr_req) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 3000; k++) begin
         if (bursts_done >= target) break;
         @(negedge RClk); #3;
      end
      check("bursts_done", bursts_done, target);
   endtask

   task automatic wait_beats(input int n);
      for (int k = 0; k < 500; k++) begin
         if (mon_in_b && mon_beats >= n) break;
         @(negedge RClk); #3;
      end
      check("reached_xfer_beats", 32'(mon_in_b && mon_beats >= n), 1);
   endtask

   // FIFO model: 1-cycle read latency, optional forced-empty stalls
   initial begin
      bit pop_pend;
      pop_pend = 0;
      Empty_in = 1'b1;
      Data_in  = '0;
      forever begin
         @(negedge RClk);
         if (PresetFull) pop_pend = 0;
         if (pop_pend && fifo_q.size() > 0) Data_in = fifo_q.pop_front();
         else Data_in = DW'($urandom);
         pop_pend = 0;
         if (stall_cnt > 0) begin
            Empty_in = 1'b1;
            stall_cnt--;
         end else if (rand_stall && $urandom_range(3) == 0) begin
            Empty_in = 1'b1;
         end else begin
            Empty_in = (fifo_q.size() == 0);
         end
         #1;
         if (Empty_in) begin
            check("readen_while_empty", ReadEn_out, 0);
         end else if (ReadEn_out && !PresetFull) begin
            pop_pend = 1;
            pops_total++;
            if (pops_total == stall_at) stall_cnt = stall_len;
         end
      end
   end

   // SDRAM controller model: delayed ack, then pulls BL beats
   initial begin
      int ph;
      int cnt;
      int nb;
      ph = 0; cnt = 0; nb = 0;
      Wr_ack = 1'b0;
      Wr_data_req = 1'b0;
      forever begin
         @(negedge RClk); #1;
         Wr_ack = 1'b0;
         if (PresetFull) begin
            ph = 0; nb = 0;
            Wr_data_req = 1'b0;
            continue;
         end
         case (ph)
            0: if (Wr_req) begin
                  cnt = (ack_delay < 0) ? int'($urandom_range(3)) : ack_delay;
                  if (cnt == 0) begin Wr_ack = 1'b1; ph = 2; end
                  else ph = 1;
               end
            1: begin
                  cnt--;
                  if (cnt == 0) begin Wr_ack = 1'b1; ph = 2; end
               end
            default: begin
                  if (nb == BL) begin
                     Wr_data_req = 1'b0;
                     nb = 0;
                     ph = 0;
                  end else begin
                     Wr_data_req = force_dreq ? 1'b1 : 1'($urandom_range(1));
                     if (Wr_data_req) nb++;
                  end
               end
         endcase
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a request/beat/done
   initial begin
      burst_t cur;
      bit exp_done;
      bit chk_drop;
      exp_done = 0; chk_drop = 0;
      cur.addr = '0; cur.fd = 0;
      forever begin
         @(negedge RClk); #2;
         if (PresetFull) begin
            mon_in_b = 0; mon_beats = 0; exp_done = 0; chk_drop = 0;
            continue;
         end
         if (exp_done) begin
            check("wr_done", Wr_done, 1);
            check("frame_done", Frame_done, cur.fd);
            exp_done = 0;
            bursts_done++;
         end else begin
            if (Wr_done) check("spurious_wr_done", Wr_done, 0);
            if (Frame_done) check("spurious_frame_done", Frame_done, 0);
         end
         if (chk_drop) begin
            check("wr_req_drop", Wr_req, 0);
            chk_drop = 0;
         end else if (Wr_req) begin
            if (exp_burst.size() == 0) begin
               check("unexpected_wr_req", Wr_req, 0);
            end else begin
               check("wr_addr", Wr_addr, exp_burst[0].addr);
               if (Wr_ack) begin
                  cur = exp_burst.pop_front();
                  mon_in_b = 1;
                  mon_beats = 0;
                  chk_drop = 1;
               end
            end
         end
         if (mon_in_b && Wr_data_req) begin
            if (exp_data.size() == 0) check("unexpected_beat", Wr_data_req, 0);
            else check("wr_data", Wr_data, exp_data.pop_front());
            mon_beats++;
            if (mon_beats == BL) begin
               mon_in_b = 0;
               exp_done = 1;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int lat;
      int target;
      int p0;
      PresetFull  = 1'b1;
      Frame_start = 1'b0;
      target      = 0;

      // Reset with FIFO non-empty, then continuous fill
      repeat (3) @(negedge RClk);
      #3;
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      @(negedge RClk); #3;
      check("rst_readen", ReadEn_out, 0);
      check("rst_wr_req", Wr_req, 0);
      check("rst_wr_addr", Wr_addr, BASE);
      check("rst_wr_data", Wr_data, 0);
      check("rst_wr_done", Wr_done, 0);
      check("rst_frame_done", Frame_done, 0);
      @(posedge RClk); #2;
      PresetFull = 1'b0;
      #1;
      check("first_pop_after_release", ReadEn_out, 1);
      wait_req(lat);
      check("req_latency_continuous", lat, 9);
      target += 1;
      wait_done(target);
      check("next_addr_after_burst1", Wr_addr, BASE + 8);

      // Empty stall of 5 cycles after the 3rd word
      ack_delay = -1;
      force_dreq = 0;
      p0 = pops_total;
      stall_at = pops_total + 3;
      stall_len = 5;
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      wait_req(lat);
      check("req_latency_stall", lat, 14);
      target += 1;
      wait_done(target);
      check("pops_per_burst", pops_total - p0, 8);
      stall_at = -1;

      // Frame wrap: 0x110, 0x118 (Frame_done), then 0x100
      for (int i = 0; i < 24; i++) push_word(DW'($urandom));
      target += 3;
      wait_done(target);

      // Frame_start during XFER of the 2nd burst of the frame
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      wait_beats(2);
      Frame_start = 1'b1;
      @(negedge RClk); #3;
      Frame_start = 1'b0;
      seg_idx = 0;
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      target += 2;
      wait_done(target);

      // Frame_start while idle restarts addressing immediately
      check("addr_before_idle_restart", Wr_addr, BASE + 8);
      Frame_start = 1'b1;
      @(negedge RClk); #3;
      Frame_start = 1'b0;
      @(negedge RClk); #3;
      check("addr_after_idle_restart", Wr_addr, BASE);
      seg_idx = 0;
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      target += 1;
      wait_done(target);

      // Reset in the middle of XFER
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      wait_beats(4);
      PresetFull = 1'b1;
      #1;
      check("midrst_wr_req", Wr_req, 0);
      check("midrst_wr_addr", Wr_addr, BASE);
      check("midrst_wr_data", Wr_data, 0);
      check("midrst_wr_done", Wr_done, 0);
      check("midrst_frame_done", Frame_done, 0);
      check("midrst_readen", ReadEn_out, 0);
      @(negedge RClk); #3;
      fifo_q.delete();
      exp_data.delete();
      exp_burst.delete();
      seg_idx = 0;
      words_pushed = 0;
      for (int i = 0; i < 8; i++) push_word(DW'($urandom));
      @(posedge RClk); #2;
      PresetFull = 1'b0;
      target += 1;
      wait_done(target);

      // Randomized traffic: trickled pushes, random stalls, ack delay, pulls
      rand_stall = 1;
      for (int i = 0; i < 48; i++) begin
         push_word(DW'($urandom));
         if ($urandom_range(2) == 0) begin
            repeat ($urandom_range(3)) @(negedge RClk);
            #3;
         end
      end
      target += 6;
      wait_done(target);
      rand_stall = 0;

      repeat (4) @(negedge RClk);
      check("leftover_data", exp_data.size(), 0);
      check("leftover_bursts", exp_burst.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain engine for the camera pixel async FIFO in the SDRAM path. It runs in the RClk domain and pops pixel words from the FIFO read port into a local burst buffer. When a full burst is collected, it issues a write-burst request with an incrementing, frame-wrapping address to the SDRAM controller, then streams the buffered beats on the controller's data request.

## Interface
Parameters:
- DATA_WIDTH, 16: width of one pixel word / SDRAM beat
- BURST_LEN, 8: words per SDRAM write burst; power of two, 2..256
- ADDR_WIDTH, 22: SDRAM word-address width
- BASE_ADDR, 0: word address of the first pixel of a frame
- FRAME_WORDS, 307200: words per frame; integer multiple of BURST_LEN

Ports:
- RClk  in  1  clock; the FIFO read clock
- PresetFull  in  1  reset PresetFull, asynchronous, active-high; clock RClk
- Empty_in  in  1  FIFO empty flag, RClk domain
- Data_in  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted ReadEn_out
- ReadEn_out  out  1  FIFO pop request
- Frame_start  in  1  single-cycle pulse: restart addressing at BASE_ADDR
- Wr_req  out  1  burst write request to the SDRAM controller
- Wr_ack  in  1  single-cycle controller acceptance of Wr_req
- Wr_addr  out  ADDR_WIDTH  start word address of the current burst; held stable while Wr_req is high
- Wr_data_req  in  1  controller pulls one beat per high cycle
- Wr_data  out  DATA_WIDTH  current beat: buf[beat_idx]
- Wr_done  out  1  one-cycle pulse after the last beat of a burst
- Frame_done  out  1  one-cycle pulse, coincident with Wr_done, for the last burst of a frame

## Operation
- Storage:
  - buf[BURST_LEN]
  - issued_cnt and captured_cnt, each 0..BURST_LEN
  - beat_idx, 0..BURST_LEN-1
  - addr register, ADDR_WIDTH bits
  - restart_pending flag
- State machine: FILL, REQ, XFER. Reset state is FILL.
- FILL:
  - ReadEn_out = !Empty_in && issued_cnt < BURST_LEN (combinational; forced 0 while PresetFull is high).
  - On each accepted pop (ReadEn_out && !Empty_in), issued_cnt increments. On the following cycle, Data_in is written to buf[captured_cnt] and captured_cnt increments.
  - When captured_cnt reaches BURST_LEN, go to REQ.
- REQ:
  - Wr_req = 1 and Wr_addr = addr.
  - On Wr_ack, go to XFER. Wr_req is low from the next cycle.
- XFER:
  - Wr_data = buf[beat_idx].
  - Each cycle Wr_data_req is high, beat_idx increments.
  - On the beat where beat_idx = BURST_LEN-1 and Wr_data_req is high:
    - Pulse Wr_done on the next cycle.
    - Set addr to addr+BURST_LEN, or to BASE_ADDR if addr+BURST_LEN = BASE_ADDR+FRAME_WORDS. In the wrap case, Frame_done pulses together with Wr_done.
    - Clear all counters and return to FILL.
- Address arithmetic: ADDR_WIDTH-bit, unsigned. The frame wrap comparison is done before truncation.
- Frame_start:
  - Sets restart_pending.
  - restart_pending is applied (addr = BASE_ADDR, flag cleared) on either of:
    - the cycle the FSM is in FILL with issued_cnt = 0;
    - the XFER to FILL transition, in which case it overrides the increment or wrap and suppresses Frame_done.
  - A burst already collected completes at its original address.
- Ignored inputs: Wr_ack outside REQ, Wr_data_req outside XFER, and Frame_start while restart_pending is already set (no extra effect).

## Timing
- Reset values:
  - ReadEn_out = 0, Wr_req = 0, Wr_addr = BASE_ADDR, Wr_data = 0 (buf cleared), Wr_done = 0, Frame_done = 0.
  - All counters = 0, restart_pending = 0.
- Reset is asynchronous. Asserting it mid-burst discards buffered words and returns to FILL.
- FIFO read latency is 1: a pop accepted at cycle t gives data captured at the t+1 edge.
- Continuous data (pops on cycles 0..7): Wr_req rises at cycle 9.
- Empty_in is sampled every cycle. A stall of N cycles delays Wr_req by N.
- Minimum burst period is 1 + BURST_LEN fill cycles, plus REQ cycles, plus BURST_LEN beat cycles, plus 1.
- No pops occur outside FILL. The FIFO absorbs backpressure.
- Wr_data changes only on Wr_data_req edges and is stable otherwise.

## Test plan
Use BURST_LEN=8, FRAME_WORDS=32, BASE_ADDR=0x100 unless noted.

- Reset: hold PresetFull high with FIFO non-empty -> ReadEn_out=0, Wr_req=0, Wr_addr=0x100. Release -> first pop occurs the cycle after release.
- Continuous fill: FIFO holds words 0x0001..0x0008 -> Wr_req at cycle 9 with Wr_addr=0x100. Ack after 3 cycles, then Wr_data_req held high -> Wr_data = 0x0001..0x0008 in order, then Wr_done pulse, next Wr_addr = 0x108.
- Empty stall: Empty_in high for 5 cycles after the 3rd word -> exactly 8 pops, no pop while empty, Wr_req delayed by 5 cycles, data order preserved.
- Frame wrap: run 4 bursts -> Wr_addr = 0x100, 0x108, 0x110, 0x118. Frame_done pulses with the 4th Wr_done. The 5th burst uses 0x100.
- Frame_start during XFER of the 2nd burst -> that burst completes at 0x108, the next burst uses 0x100, and no Frame_done pulse occurs.
- Reset mid-XFER after 4 beats -> outputs return to reset values immediately. The next burst carries new FIFO words at 0x100.
